// File: rtl/calc_sequencer_if.sv
// Board-side bus of the calculator sequencer: switches, raw buttons, ALU operands/result and display.
// master = board/ALU environment, slave = calc_sequencer.
interface calc_sequencer_if;
  logic [3:0] sw;
  logic       op_sw;
  logic       btn_enter;
  logic       btn_clear;
  logic [3:0] operand1;
  logic [3:0] operand2;
  logic       operator_sel;
  logic [4:0] alu_result;
  logic [4:0] result;
  logic       result_valid;
  logic [4:0] disp_value;
  logic [1:0] state_led;

  modport master (
    output sw, op_sw, btn_enter, btn_clear, alu_result,
    input  operand1, operand2, operator_sel, result, result_valid, disp_value, state_led
  );

  modport slave (
    input  sw, op_sw, btn_enter, btn_clear, alu_result,
    output operand1, operand2, operator_sel, result, result_valid, disp_value, state_led
  );
endinterface

// File: rtl/calc_sequencer.sv
// Sequences operand/operator capture for the 4-bit ALU from buttons and registers its result for display.
// Optional button debounce filter enabled by defining CALC_DEBOUNCE_EN.
module calc_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input logic           clk,
  input logic           rst,
  calc_sequencer_if.slave bus
);

  localparam logic [1:0] ST_ENTER_A = 2'b00;
  localparam logic [1:0] ST_ENTER_B = 2'b01;
  localparam logic [1:0] ST_COMPUTE = 2'b10;
  localparam logic [1:0] ST_SHOW    = 2'b11;

`ifdef CALC_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  // Bit 0 = Enter, bit 1 = Clear throughout the conditioning chain.
  logic [1:0] btn_raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] level;
  logic [1:0] level_d;
  logic [1:0] pulse;
  logic       enter_p;
  logic       clear_p;

  assign btn_raw = {bus.btn_clear, bus.btn_enter};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  generate
    for (genvar i = 0; i < 2; i++) begin : g_btn
      if (DB_EN && (DEBOUNCE_CYCLES > 0)) begin : g_db
        localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
        logic [CW-1:0] cnt;
        logic          lvl_q;

        // Level flips only after an unbroken run of differing samples.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            cnt   <= '0;
            lvl_q <= 1'b0;
          end else if (sync2[i] == lvl_q) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            lvl_q <= ~lvl_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        assign level[i] = lvl_q;
      end else begin : g_direct
        assign level[i] = sync2[i];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= 2'b00;
      pulse   <= 2'b00;
    end else begin
      level_d <= level;
      pulse   <= level & ~level_d;
    end
  end

  assign enter_p = pulse[0];
  assign clear_p = pulse[1];

  logic [1:0] state;
  logic [3:0] op1_q;
  logic [3:0] op2_q;
  logic       opsel_q;
  logic [4:0] result_q;
  logic       valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_ENTER_A;
      op1_q    <= 4'd0;
      op2_q    <= 4'd0;
      opsel_q  <= 1'b0;
      result_q <= 5'd0;
      valid_q  <= 1'b0;
    end else if (clear_p) begin
      // Clear takes priority; a coincident Enter is dropped.
      state    <= ST_ENTER_A;
      op1_q    <= 4'd0;
      op2_q    <= 4'd0;
      opsel_q  <= 1'b0;
      result_q <= 5'd0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        ST_ENTER_A: begin
          if (enter_p) begin
            op1_q <= bus.sw;
            state <= ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (enter_p) begin
            op2_q   <= bus.sw;
            opsel_q <= bus.op_sw;
            state   <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          result_q <= bus.alu_result;
          valid_q  <= 1'b1;
          state    <= ST_SHOW;
        end
        ST_SHOW: begin
          if (enter_p) begin
            valid_q <= 1'b0;
            state   <= ST_ENTER_A;
          end
        end
        default: state <= ST_ENTER_A;
      endcase
    end
  end

  assign bus.operand1     = op1_q;
  assign bus.operand2     = op2_q;
  assign bus.operator_sel = opsel_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.state_led    = state;
  // COMPUTE and SHOW both have the MSB set: show the result, otherwise the live switches.
  assign bus.disp_value   = state[1] ? result_q : {1'b0, bus.sw};

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: drives switches/buttons, models the ALU, and checks against a press-level model.
module tb_calc_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  calc_sequencer_if bus ();

  calc_sequencer #(.DEBOUNCE_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Environment ALU: 5-bit two's complement add/subtract of the registered operands.
  assign bus.alu_result = bus.operator_sel ? ({1'b0, bus.operand1} + {1'b0, bus.operand2})
                                           : ({1'b0, bus.operand1} - {1'b0, bus.operand2});

  int total = 0;
  int bad   = 0;
  bit model_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Press-level model: a button sampled high at edge N (low at N-1) is acted on at edge N+3.
  int         m_state;
  logic [3:0] m_op1, m_op2;
  logic       m_opsel, m_vld;
  logic [4:0] m_res;
  logic [3:0] eh, ch;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_op1 = 0; m_op2 = 0; m_opsel = 0; m_res = 0; m_vld = 0;
      eh = 0; ch = 0;
    end else begin
      bit e_act, c_act;
      int v;
      e_act = eh[2] & ~eh[3];
      c_act = ch[2] & ~ch[3];
      if (c_act) begin
        m_state = 0; m_op1 = 0; m_op2 = 0; m_opsel = 0; m_res = 0; m_vld = 0;
      end else if (m_state == 0) begin
        if (e_act) begin m_op1 = bus.sw; m_state = 1; end
      end else if (m_state == 1) begin
        if (e_act) begin m_op2 = bus.sw; m_opsel = bus.op_sw; m_state = 2; end
      end else if (m_state == 2) begin
        v = m_opsel ? (int'(m_op1) + int'(m_op2)) : (int'(m_op1) - int'(m_op2));
        m_res = v[4:0];
        m_vld = 1'b1;
        m_state = 3;
      end else if (e_act) begin
        m_vld = 1'b0;
        m_state = 0;
      end
      eh = {eh[2:0], bus.btn_enter};
      ch = {ch[2:0], bus.btn_clear};
    end
  end

  always @(posedge clk) begin
    #3;
    if (model_on && !rst) begin
      check("state_led", bus.state_led, m_state);
      check("operand1", bus.operand1, m_op1);
      check("operand2", bus.operand2, m_op2);
      check("operator_sel", bus.operator_sel, m_opsel);
      check("result", bus.result, m_res);
      check("result_valid", bus.result_valid, m_vld);
      check("disp_value", bus.disp_value, (m_state >= 2) ? int'(m_res) : int'(bus.sw));
    end
  end

  task automatic press(input bit e, input bit c, input int hold, input int gap);
    @(negedge clk);
    bus.btn_enter = e;
    bus.btn_clear = c;
    repeat (hold) @(negedge clk);
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic calc(input logic [3:0] a, input logic [3:0] b, input logic op);
    bus.sw = a;
    press(1'b1, 1'b0, 3, 4);
    bus.sw = b;
    bus.op_sw = op;
    press(1'b1, 1'b0, 3, 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    bus.sw = 4'hA;
    bus.op_sw = 1'b0;
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    repeat (2) @(negedge clk);

    check("rst state_led", bus.state_led, 0);
    check("rst operand1", bus.operand1, 0);
    check("rst operand2", bus.operand2, 0);
    check("rst operator_sel", bus.operator_sel, 0);
    check("rst result", bus.result, 0);
    check("rst result_valid", bus.result_valid, 0);
    check("rst disp_value", bus.disp_value, 5'h0A);
    rst = 1'b0;
`ifndef CALC_DEBOUNCE_EN
    model_on = 1'b1;
    repeat (2) @(negedge clk);

    calc(4'd3, 4'd5, 1'b1);
    check("add result", bus.result, 5'b01000);
    check("add valid", bus.result_valid, 1);
    check("add state", bus.state_led, 2'b11);
    check("add disp", bus.disp_value, 5'b01000);

    bus.sw = 4'd9;
    press(1'b1, 1'b0, 3, 4);
    check("show->A state", bus.state_led, 2'b00);
    check("show->A valid", bus.result_valid, 0);
    check("show->A result kept", bus.result, 5'b01000);
    check("show->A disp live", bus.disp_value, 5'd9);

    calc(4'd3, 4'd5, 1'b0);
    check("sub result", bus.result, 5'b11110);
    check("sub disp", bus.disp_value, 5'b11110);
    press(1'b1, 1'b0, 3, 4);

    bus.sw = 4'd7;
    press(1'b1, 1'b0, 12, 4);
    check("held press one advance", bus.state_led, 2'b01);
    check("held press operand1", bus.operand1, 7);
    press(1'b0, 1'b1, 3, 4);
    check("clear state", bus.state_led, 2'b00);
    check("clear operand1", bus.operand1, 0);
    check("clear valid", bus.result_valid, 0);

    bus.sw = 4'd9;
    bus.op_sw = 1'b1;
    press(1'b1, 1'b0, 3, 4);
    bus.sw = 4'd4;
    @(negedge clk);
    bus.btn_enter = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (bus.state_led == 2'b10) found = 1'b1;
    end
    check("reached COMPUTE", int'(found), 1);
    rst = 1'b1;
    bus.btn_enter = 1'b0;
    #1;
    check("abort state", bus.state_led, 2'b00);
    check("abort operand1", bus.operand1, 0);
    check("abort operand2", bus.operand2, 0);
    check("abort operator_sel", bus.operator_sel, 0);
    check("abort result", bus.result, 0);
    check("abort valid", bus.result_valid, 0);
    check("abort disp", bus.disp_value, 5'd4);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("valid stays low", bus.result_valid, 0);
    end

    calc(4'd15, 4'd15, 1'b1);
    check("wrap result", bus.result, 5'b11110);
    check("wrap state", bus.state_led, 2'b11);
    press(1'b1, 1'b1, 3, 4);
    check("clear wins state", bus.state_led, 2'b00);
    check("clear wins result", bus.result, 0);
    check("clear wins valid", bus.result_valid, 0);
    check("clear wins operand1", bus.operand1, 0);
`else
    repeat (2) @(negedge clk);
    bus.sw = 4'd6;
    for (int g = 0; g < 3; g++) begin
      press(1'b1, 1'b0, 10, 10);
      check("glitch no advance", bus.state_led, 2'b00);
    end
    check("glitch operand1", bus.operand1, 0);
    press(1'b1, 1'b0, 20, 30);
    check("debounced press state", bus.state_led, 2'b01);
    check("debounced press operand1", bus.operand1, 6);
    repeat (30) @(negedge clk);
    check("release no advance", bus.state_led, 2'b01);
    check("release operand2", bus.operand2, 0);
`endif
    model_on = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
